stream_checker: RTL and testbench

- Sink-side checker for the benchmark bench's 32-bit valid/ready data stream.
- Consumes the words a stimulus driver presents and applies a programmable backpressure pattern to exercise the handshake.
- Compares every accepted word against an internally generated expected sequence (incrementing or LFSR).
- Reports word count, error count, first-mismatch details, timeout and a pass/fail verdict, so benches check one status bit instead of printing data.

---
 rtl/stream_checker.sv | 183 ++++++++++++++++++
 tb/tb_stream_checker.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/stream_checker.sv
// stream_checker
//   Sink-side checker for a valid/ready data stream. Accepts words under a
//   programmable 4-phase backpressure pattern and compares each accepted word
//   against an internally generated sequence: incrementing, or a 32-bit Galois
//   LFSR. Reports counts, first-mismatch details, timeout and a pass verdict.
//
// Ports
//   clk, rst_n        clock, synchronous active-low reset
//   start             one-cycle pulse; begins a run (ignored while busy)
//   mode              0 = incrementing, 1 = LFSR            (sampled on start)
//   seed              first expected word                   (sampled on start)
//   expected_count    words in the run                      (sampled on start)
//   bp_mask           backpressure pattern, bit[phase]=1 stalls (sampled on start)
//   in_data/in_valid  stream input
//   in_ready          stream ready (from registered state only)
//   busy/done         RUN / DONE state indicators
//   pass              done && no errors && no timeout
//   timeout           run aborted after TIMEOUT idle RUN cycles
//   word_count        words accepted this run
//   err_count         mismatches this run (saturating)
//   first_err_idx/_data/_exp  details of the first mismatch
module stream_checker #(
    parameter int DATA_W  = 32,
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              mode,
    input  logic [DATA_W-1:0] seed,
    input  logic [CNT_W-1:0]  expected_count,
    input  logic [3:0]        bp_mask,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              timeout,
    output logic [CNT_W-1:0]  word_count,
    output logic [CNT_W-1:0]  err_count,
    output logic [CNT_W-1:0]  first_err_idx,
    output logic [DATA_W-1:0] first_err_data,
    output logic [DATA_W-1:0] first_err_exp
);

    localparam int IDLE_W = $clog2(TIMEOUT + 1);
    localparam logic [DATA_W-1:0] LFSR_TAPS = DATA_W'(32'h80200003);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic                mode_q, mode_d;
    logic [CNT_W-1:0]    exp_cnt_q, exp_cnt_d;
    logic [3:0]          bp_q, bp_d;
    logic [DATA_W-1:0]   exp_q, exp_d;
    logic [1:0]          phase_q, phase_d;
    logic [IDLE_W-1:0]   idle_q, idle_d;
    logic                timeout_q, timeout_d;
    logic [CNT_W-1:0]    word_q, word_d;
    logic [CNT_W-1:0]    err_q, err_d;
    logic [CNT_W-1:0]    fidx_q, fidx_d;
    logic [DATA_W-1:0]   fdata_q, fdata_d;
    logic [DATA_W-1:0]   fexp_q, fexp_d;

    logic                accept;
    logic [DATA_W-1:0]   exp_next;

    always_comb begin
        in_ready = (state_q == S_RUN) && !bp_q[phase_q];
        accept   = in_valid && in_ready;
        exp_next = mode_q ? ({1'b0, exp_q[DATA_W-1:1]} ^ (exp_q[0] ? LFSR_TAPS : '0))
                          : exp_q + DATA_W'(1);

        state_d   = state_q;
        mode_d    = mode_q;
        exp_cnt_d = exp_cnt_q;
        bp_d      = bp_q;
        exp_d     = exp_q;
        phase_d   = phase_q;
        idle_d    = idle_q;
        timeout_d = timeout_q;
        word_d    = word_q;
        err_d     = err_q;
        fidx_d    = fidx_q;
        fdata_d   = fdata_q;
        fexp_d    = fexp_q;

        case (state_q)
            S_RUN: begin
                phase_d = phase_q + 2'd1;
                if (accept) begin
                    idle_d = '0;
                    word_d = word_q + CNT_W'(1);
                    exp_d  = exp_next;
                    if (in_data != exp_q) begin
                        if (err_q != '1) err_d = err_q + CNT_W'(1);
                        if (err_q == '0) begin
                            fidx_d  = word_q;
                            fdata_d = in_data;
                            fexp_d  = exp_q;
                        end
                    end
                    if (word_q + CNT_W'(1) == exp_cnt_q) state_d = S_DONE;
                end else if (idle_q == IDLE_W'(TIMEOUT - 1)) begin
                    timeout_d = 1'b1;
                    state_d   = S_DONE;
                end else begin
                    idle_d = idle_q + IDLE_W'(1);
                end
            end
            default: begin
                if (start) begin
                    mode_d    = mode;
                    exp_cnt_d = expected_count;
                    // An all-stall pattern would deadlock the stream; keep phase 0 open.
                    bp_d      = (bp_mask == 4'hF) ? 4'hE : bp_mask;
                    // The all-zero state is a fixed point of the LFSR.
                    exp_d     = (mode && seed == '0) ? DATA_W'(1) : seed;
                    phase_d   = '0;
                    idle_d    = '0;
                    timeout_d = 1'b0;
                    word_d    = '0;
                    err_d     = '0;
                    fidx_d    = '0;
                    fdata_d   = '0;
                    fexp_d    = '0;
                    state_d   = (expected_count == '0) ? S_DONE : S_RUN;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            mode_q    <= 1'b0;
            exp_cnt_q <= '0;
            bp_q      <= '0;
            exp_q     <= '0;
            phase_q   <= '0;
            idle_q    <= '0;
            timeout_q <= 1'b0;
            word_q    <= '0;
            err_q     <= '0;
            fidx_q    <= '0;
            fdata_q   <= '0;
            fexp_q    <= '0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            exp_cnt_q <= exp_cnt_d;
            bp_q      <= bp_d;
            exp_q     <= exp_d;
            phase_q   <= phase_d;
            idle_q    <= idle_d;
            timeout_q <= timeout_d;
            word_q    <= word_d;
            err_q     <= err_d;
            fidx_q    <= fidx_d;
            fdata_q   <= fdata_d;
            fexp_q    <= fexp_d;
        end
    end

    always_comb begin
        busy           = (state_q == S_RUN);
        done           = (state_q == S_DONE);
        pass           = done && (err_q == '0) && !timeout_q;
        timeout        = timeout_q;
        word_count     = word_q;
        err_count      = err_q;
        first_err_idx  = fidx_q;
        first_err_data = fdata_q;
        first_err_exp  = fexp_q;
    end

endmodule

// File: tb/tb_stream_checker.sv
// Testbench for stream_checker: drives runs with random and directed
// parameters and checks every cycle and every final status against a
// behavioural model of the expected sequence and run rules.
module tb_stream_checker;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        mode;
    logic [31:0] seed;
    logic [15:0] expected_count;
    logic [3:0]  bp_mask;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic        busy;
    logic        done;
    logic        pass;
    logic        timeout;
    logic [15:0] word_count;
    logic [15:0] err_count;
    logic [15:0] first_err_idx;
    logic [31:0] first_err_data;
    logic [31:0] first_err_exp;

    int total = 0;
    int bad   = 0;

    stream_checker #(
        .DATA_W (32),
        .CNT_W  (16),
        .TIMEOUT(TO)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .mode          (mode),
        .seed          (seed),
        .expected_count(expected_count),
        .bp_mask       (bp_mask),
        .in_data       (in_data),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .busy          (busy),
        .done          (done),
        .pass          (pass),
        .timeout       (timeout),
        .word_count    (word_count),
        .err_count     (err_count),
        .first_err_idx (first_err_idx),
        .first_err_data(first_err_data),
        .first_err_exp (first_err_exp)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Next word of the reference sequence.
    function automatic logic [31:0] seq_next(input logic m, input logic [31:0] x);
        logic [31:0] r;
        if (m) r = (x >> 1) ^ (x[0] ? 32'h80200003 : 32'h0);
        else   r = x + 32'd1;
        return r;
    endfunction

    // Run one check pass. cN_idx >= 0 forces word cN_idx to cN_val;
    // stop_after >= 0 drops valid once that many words were accepted.
    task automatic run_case(input string tag, input logic m, input logic [31:0] sd,
                            input int cnt, input logic [3:0] bp, input int valid_pct,
                            input int err_pct, input int stop_after,
                            input int c1_idx, input logic [31:0] c1_val,
                            input int c2_idx, input logic [31:0] c2_val,
                            input bit mid_start);
        logic [31:0] e, d, fdat, fexp;
        logic [3:0]  bpe;
        int          wc, ec, fidx, idle, cyc;
        bit          to, fin, v, rdy;
        bpe  = (bp == 4'hF) ? 4'hE : bp;
        e    = (m && sd == 32'h0) ? 32'h1 : sd;
        wc = 0; ec = 0; fidx = 0; fdat = 0; fexp = 0; idle = 0; cyc = 0; to = 0;

        @(negedge clk);
        mode = m; seed = sd; expected_count = 16'(cnt); bp_mask = bp;
        start = 1'b1; in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        // Scramble the run parameters: the DUT must have latched them.
        mode = ~m; seed = $urandom; expected_count = 16'($urandom); bp_mask = 4'($urandom);
        fin = (cnt == 0);

        while (!fin && cyc < 2000) begin
            #1;
            chk({tag, ".busy"}, 32'(busy), 32'd1);
            chk({tag, ".done_run"}, 32'(done), 32'd0);
            chk({tag, ".ready"}, 32'(in_ready), 32'(!bpe[cyc % 4]));
            chk({tag, ".wc_run"}, 32'(word_count), 32'(wc));
            chk({tag, ".ec_run"}, 32'(err_count), 32'(ec));
            if (stop_after >= 0 && wc >= stop_after) v = 1'b0;
            else v = ($urandom_range(99) < valid_pct);
            d = e;
            if (wc == c1_idx) d = c1_val;
            else if (wc == c2_idx) d = c2_val;
            else if ($urandom_range(99) < err_pct) d = e ^ ($urandom | 32'h1);
            in_valid = v;
            in_data  = v ? d : $urandom;
            if (mid_start && cyc == 2) begin
                start = 1'b1; mode = ~m; seed = $urandom; expected_count = 16'h0; bp_mask = 4'hF;
            end
            rdy = !bpe[cyc % 4];
            @(posedge clk);
            if (v && rdy) begin
                if (d !== e) begin
                    if (ec == 0) begin fidx = wc; fdat = d; fexp = e; end
                    ec++;
                end
                wc++;
                e = seq_next(m, e);
                idle = 0;
                if (wc == cnt) fin = 1;
            end else begin
                idle++;
                if (idle == TO) begin to = 1; fin = 1; end
            end
            cyc++;
            @(negedge clk);
            in_valid = 1'b0;
            start    = 1'b0;
        end
        chk({tag, ".budget"}, 32'(fin), 32'd1);

        #1;
        chk({tag, ".done"}, 32'(done), 32'd1);
        chk({tag, ".busy_end"}, 32'(busy), 32'd0);
        chk({tag, ".ready_end"}, 32'(in_ready), 32'd0);
        chk({tag, ".pass"}, 32'(pass), 32'(ec == 0 && !to));
        chk({tag, ".timeout"}, 32'(timeout), 32'(to));
        chk({tag, ".wc"}, 32'(word_count), 32'(wc));
        chk({tag, ".ec"}, 32'(err_count), 32'(ec));
        chk({tag, ".fidx"}, 32'(first_err_idx), 32'(fidx));
        chk({tag, ".fdat"}, first_err_data, fdat);
        chk({tag, ".fexp"}, first_err_exp, fexp);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; mode = 1'b0; seed = '0; expected_count = '0;
        bp_mask = '0; in_data = '0; in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.done", 32'(done), 32'd0);
        chk("rst.pass", 32'(pass), 32'd0);
        chk("rst.ready", 32'(in_ready), 32'd0);
        chk("rst.wc", 32'(word_count), 32'd0);
        chk("rst.fexp", first_err_exp, 32'd0);
        rst_n = 1'b1;

        // Valid while idle is ignored.
        in_valid = 1'b1; in_data = 32'h1;
        @(posedge clk); @(negedge clk);
        chk("idle.ready", 32'(in_ready), 32'd0);
        chk("idle.wc", 32'(word_count), 32'd0);
        in_valid = 1'b0;

        run_case("basic", 1'b0, 32'h12345678, 8, 4'h0, 100, 0, -1, -1, 0, -1, 0, 1'b0);
        chk("basic.pass_const", 32'(pass), 32'd1);
        run_case("bp1010", 1'b0, 32'h0000_0100, 4, 4'b1010, 100, 0, -1, -1, 0, -1, 0, 1'b0);
        run_case("bpF", 1'b1, 32'hACE1_0001, 4, 4'hF, 100, 0, -1, -1, 0, -1, 0, 1'b0);
        run_case("mism", 1'b0, 32'h10, 5, 4'h0, 100, 0, -1, 2, 32'hDEAD, 4, 32'h0, 1'b0);
        chk("mism.ec_const", 32'(err_count), 32'd2);
        chk("mism.fexp_const", first_err_exp, 32'h12);
        run_case("lfsr0", 1'b1, 32'h0, 20, 4'h0, 100, 0, -1, -1, 0, -1, 0, 1'b0);
        run_case("wrap", 1'b0, 32'hFFFF_FFFF, 2, 4'h0, 100, 0, -1, -1, 0, -1, 0, 1'b0);
        run_case("tmo", 1'b0, 32'h55, 4, 4'h0, 100, 0, 1, -1, 0, -1, 0, 1'b0);
        chk("tmo.timeout_const", 32'(timeout), 32'd1);
        run_case("cnt0", 1'b0, 32'h77, 0, 4'h0, 100, 0, -1, -1, 0, -1, 0, 1'b0);
        run_case("midstart", 1'b1, 32'h1234, 10, 4'b0100, 80, 0, -1, -1, 0, -1, 0, 1'b1);

        // Valid while DONE is ignored and status holds.
        in_valid = 1'b1; in_data = 32'h0;
        @(posedge clk); @(negedge clk);
        chk("doneidle.wc", 32'(word_count), 32'd10);
        chk("doneidle.ready", 32'(in_ready), 32'd0);
        in_valid = 1'b0;

        for (int i = 0; i < 12; i++) begin
            run_case("rand", 1'($urandom), $urandom, int'($urandom_range(40)),
                     4'($urandom), int'($urandom_range(100, 50)), (i % 3 == 0) ? 10 : 0,
                     -1, -1, 0, -1, 0, 1'b0);
        end

        // Reset in the middle of a run.
        @(negedge clk);
        mode = 1'b0; seed = 32'h9; expected_count = 16'd50; bp_mask = 4'h0; start = 1'b1;
        @(posedge clk); @(negedge clk);
        start = 1'b0; in_valid = 1'b1; in_data = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0; rst_n = 1'b0;
        @(posedge clk); @(negedge clk);
        rst_n = 1'b1;
        chk("mrst.busy", 32'(busy), 32'd0);
        chk("mrst.done", 32'(done), 32'd0);
        chk("mrst.ready", 32'(in_ready), 32'd0);
        chk("mrst.ec", 32'(err_count), 32'd0);
        chk("mrst.wc", 32'(word_count), 32'd0);
        chk("mrst.fidx", 32'(first_err_idx), 32'd0);
        run_case("afterrst", 1'b1, 32'hBEEF, 6, 4'h0, 100, 0, -1, -1, 0, -1, 0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
